// File: rtl/keypad_pkg.sv
// Shared definitions for the 12-key launchpad keypad scanner: key count,
// code width, mux-order key codes and the scan index successor.
package keypad_pkg;

   localparam int NUM_KEYS = 12;
   localparam int KEY_W    = 4;

   typedef enum logic [KEY_W-1:0] {
      KEY_1     = 4'd0,
      KEY_2     = 4'd1,
      KEY_3     = 4'd2,
      KEY_4     = 4'd3,
      KEY_5     = 4'd4,
      KEY_6     = 4'd5,
      KEY_7     = 4'd6,
      KEY_8     = 4'd7,
      KEY_9     = 4'd8,
      KEY_STAR  = 4'd9,
      KEY_0     = 4'd10,
      KEY_SHARP = 4'd11
   } key_code_e;

   // Next scan index; anything at or beyond the last key folds back to 0
   function automatic logic [KEY_W-1:0] next_key(input logic [KEY_W-1:0] k);
      logic [KEY_W-1:0] n;
      if (k >= KEY_W'(NUM_KEYS - 1)) begin
         n = {KEY_W{1'b0}};
      end else begin
         n = k + KEY_W'(1'b1);
      end
      return n;
   endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Press-event FIFO: first-word-fall-through head register, valid/ready pop,
// and a sticky overflow flag for pushes refused while full.
module keypad_evt_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             ready,
   input  logic             clr_ovf,
   output logic             valid,
   output logic [WIDTH-1:0] dout,
   output logic             ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    rd_ptr_r;
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_next_s;
   logic [CW-1:0]    count_r;
   logic [CW-1:0]    remain_s;
   logic [CW-1:0]    count_next_s;
   logic [WIDTH-1:0] dout_r;
   logic [WIDTH-1:0] head_next_s;
   logic             valid_r;
   logic             ovf_r;
   logic             pop_s;
   logic             full_s;
   logic             push_ok_s;
   logic             ovf_set_s;

   // Qualify pop/push and pick the head the output register shows next
   always_comb begin
      pop_s        = valid_r & ready;
      full_s       = (count_r == CW'(DEPTH));
      push_ok_s    = push & (~full_s | pop_s);
      ovf_set_s    = push & full_s & ~pop_s;
      rd_next_s    = rd_ptr_r + AW'(pop_s);
      remain_s     = count_r - CW'(pop_s);
      count_next_s = remain_s + CW'(push_ok_s);
      head_next_s  = dout_r;
      if (remain_s != {CW{1'b0}}) begin
         head_next_s = mem_r[rd_next_s];
      end else if (push_ok_s) begin
         head_next_s = din;
      end else begin
         head_next_s = dout_r;
      end
   end

   // Storage, pointers, registered head/valid and sticky overflow (set wins)
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
         rd_ptr_r <= {AW{1'b0}};
         wr_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
         dout_r   <= {WIDTH{1'b0}};
         valid_r  <= 1'b0;
         ovf_r    <= 1'b0;
      end else begin
         if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
            wr_ptr_r        <= wr_ptr_r + AW'(1'b1);
         end
         rd_ptr_r <= rd_next_s;
         count_r  <= count_next_s;
         dout_r   <= head_next_s;
         valid_r  <= (count_next_s != {CW{1'b0}});
         if (ovf_set_s) begin
            ovf_r <= 1'b1;
         end else if (clr_ovf) begin
            ovf_r <= 1'b0;
         end
      end
   end

   assign valid = valid_r;
   assign dout  = dout_r;
   assign ovf   = ovf_r;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan sequencer: steps the key-mux index, debounces each key on its
// own visit and queues a key code for every debounced press.
module keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV   = 10,
   parameter int DEB_CNT    = 3,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                EN,
   input  logic                KEY_IN,
   output logic [KEY_W-1:0]    SEL,
   output logic [NUM_KEYS-1:0] KEY_HELD,
   output logic                KEY_VALID,
   output logic [KEY_W-1:0]    KEY_CODE,
   input  logic                KEY_READY,
   output logic                OVF,
   input  logic                CLR_OVF
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEB_CNT + 1);

   logic [PW-1:0]       presc_r;
   logic [KEY_W-1:0]    sel_r;
   logic [CW-1:0]       cnt_r [NUM_KEYS];
   logic [NUM_KEYS-1:0] held_r;
   logic                push_r;
   logic [KEY_W-1:0]    push_code_r;

   logic                tc_s;
   logic                cur_held_s;
   logic [CW-1:0]       cnt_inc_s;
   logic [CW-1:0]       cnt_new_s;
   logic                flip_s;

   // Debounce decision for the key currently on the mux
   always_comb begin
      tc_s       = EN && (presc_r == PW'(SCAN_DIV - 1));
      cur_held_s = held_r[sel_r];
      cnt_inc_s  = cnt_r[sel_r] + CW'(1'b1);
      cnt_new_s  = {CW{1'b0}};
      flip_s     = 1'b0;
      if (KEY_IN == cur_held_s) begin
         cnt_new_s = {CW{1'b0}};
         flip_s    = 1'b0;
      end else if (cnt_inc_s == CW'(DEB_CNT)) begin
         cnt_new_s = {CW{1'b0}};
         flip_s    = 1'b1;
      end else begin
         cnt_new_s = cnt_inc_s;
         flip_s    = 1'b0;
      end
   end

   // Prescaler, scan index, debounce array and the one-cycle push request
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         presc_r     <= {PW{1'b0}};
         sel_r       <= {KEY_W{1'b0}};
         held_r      <= {NUM_KEYS{1'b0}};
         push_r      <= 1'b0;
         push_code_r <= {KEY_W{1'b0}};
         for (int i = 0; i < NUM_KEYS; i++) begin
            cnt_r[i] <= {CW{1'b0}};
         end
      end else begin
         push_r <= 1'b0;
         if (tc_s) begin
            presc_r      <= {PW{1'b0}};
            sel_r        <= next_key(sel_r);
            cnt_r[sel_r] <= cnt_new_s;
            if (flip_s) begin
               held_r[sel_r] <= ~cur_held_s;
               // Only the press edge queues an event; releases stay silent
               push_r        <= ~cur_held_s;
               push_code_r   <= sel_r;
            end
         end else if (EN) begin
            presc_r <= presc_r + PW'(1'b1);
         end
      end
   end

   keypad_evt_fifo #(
      .WIDTH (KEY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk     (CLK),
      .rst_n   (RST),
      .push    (push_r),
      .din     (push_code_r),
      .ready   (KEY_READY),
      .clr_ovf (CLR_OVF),
      .valid   (KEY_VALID),
      .dout    (KEY_CODE),
      .ovf     (OVF)
   );

   assign SEL      = sel_r;
   assign KEY_HELD = held_r;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: directed scenarios plus random key activity,
// compared each cycle against a behavioural scan/debounce/queue model.
module tb_keypad_scan_ctrl;
   import keypad_pkg::*;

   localparam int SCAN_DIV   = 10;
   localparam int DEB_CNT    = 3;
   localparam int FIFO_DEPTH = 4;
   localparam int VISIT      = NUM_KEYS * SCAN_DIV;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        EN = 1'b0;
   logic        KEY_READY = 1'b0;
   logic        CLR_OVF = 1'b0;
   logic        KEY_IN;
   logic [3:0]  SEL;
   logic [11:0] KEY_HELD;
   logic        KEY_VALID;
   logic [3:0]  KEY_CODE;
   logic        OVF;

   logic [11:0] pressed = 12'h000;
   logic        noise = 1'b0;
   bit          cmp_en = 1'b0;
   bit          pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
   int          n_checks = 0;
   int          n_pass = 0;

   // behavioural model state
   int          m_phase = 0;
   int          m_idx = 0;
   int          m_cnt [12];
   logic [11:0] m_held = 12'h000;
   int          q [$];
   int          m_code = 0;
   bit          m_ovf = 1'b0;
   bit          m_pend = 1'b0;
   int          m_pcode = 0;

   assign KEY_IN = pressed[SEL] ^ noise;

   keypad_scan_ctrl #(
      .SCAN_DIV   (SCAN_DIV),
      .DEB_CNT    (DEB_CNT),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .EN        (EN),
      .KEY_IN    (KEY_IN),
      .SEL       (SEL),
      .KEY_HELD  (KEY_HELD),
      .KEY_VALID (KEY_VALID),
      .KEY_CODE  (KEY_CODE),
      .KEY_READY (KEY_READY),
      .OVF       (OVF),
      .CLR_OVF   (CLR_OVF)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   task automatic wait_sel(input int s, input string name);
      int t = 0;
      while (SEL !== 4'(s) && t < 300) begin
         tick(1);
         t++;
      end
      if (t >= 300) chk(name, SEL, s);
   endtask

   // Model: one scan step per SCAN_DIV enabled cycles, per-key disagreement
   // counters, and a queue of press codes trailing the debounce by one cycle.
   always @(posedge CLK or negedge RST) begin
      bit pop;
      bit drop;
      bit npend;
      int npcode;
      if (!RST) begin
         m_phase = 0;
         m_idx   = 0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
         m_held  = 12'h000;
         q.delete();
         m_code  = 0;
         m_ovf   = 1'b0;
         m_pend  = 1'b0;
         m_pcode = 0;
      end else begin
         pop  = (q.size() > 0) && KEY_READY;
         drop = m_pend && (q.size() == FIFO_DEPTH) && !pop;
         if (pop) void'(q.pop_front());
         if (m_pend && !drop) q.push_back(m_pcode);
         if (drop) m_ovf = 1'b1;
         else if (CLR_OVF) m_ovf = 1'b0;
         if (q.size() > 0) m_code = q[0];
         npend  = 1'b0;
         npcode = m_pcode;
         if (EN) begin
            if (m_phase == SCAN_DIV - 1) begin
               if (KEY_IN == m_held[m_idx]) begin
                  m_cnt[m_idx] = 0;
               end else begin
                  m_cnt[m_idx] = m_cnt[m_idx] + 1;
                  if (m_cnt[m_idx] == DEB_CNT) begin
                     m_held[m_idx] = !m_held[m_idx];
                     m_cnt[m_idx]  = 0;
                     if (m_held[m_idx]) begin
                        npend  = 1'b1;
                        npcode = m_idx;
                     end
                  end
               end
               m_idx   = (m_idx + 1) % NUM_KEYS;
               m_phase = 0;
            end else begin
               m_phase = m_phase + 1;
            end
         end
         m_pend  = npend;
         m_pcode = npcode;
      end
   end

   always @(negedge CLK) begin
      if (cmp_en) begin
         chk("sel", SEL, m_idx);
         chk("held", KEY_HELD, m_held);
         chk("valid", KEY_VALID, q.size() > 0);
         chk("code", KEY_CODE, m_code);
         chk("ovf", OVF, m_ovf);
      end
   end

   initial begin
      int frz_sel;
      int t;
      int k;
      int exp7 [4] = '{1, 2, 3, 7};

      RST = 1'b0;
      tick(3);
      chk("rst_sel", SEL, 0);
      chk("rst_valid", KEY_VALID, 0);
      chk("rst_code", KEY_CODE, 0);
      chk("rst_ovf", OVF, 0);
      chk("rst_held", KEY_HELD, 0);
      cmp_en = 1'b1;
      RST = 1'b1;
      EN  = 1'b1;

      // scan index stepping, each value held SCAN_DIV cycles
      for (int i = 0; i < 13; i++) begin
         tick(SCAN_DIV - 1);
         chk("sel_hold", SEL, i % 12);
         tick(1);
         chk("sel_step", SEL, (i + 1) % 12);
         chk("sel_novalid", KEY_VALID, 0);
      end

      // key 4 press and release
      pressed[4] = 1'b1;
      tick(4 * VISIT);
      chk("k4_held", KEY_HELD, 12'h010);
      chk("k4_valid", KEY_VALID, 1);
      chk("k4_code", KEY_CODE, 4);
      KEY_READY = 1'b1;
      tick(1);
      KEY_READY = 1'b0;
      tick(2 * VISIT);
      chk("k4_single_evt", KEY_VALID, 0);
      pressed[4] = 1'b0;
      tick(4 * VISIT);
      chk("k4_release", KEY_HELD, 12'h000);
      chk("k4_release_noevt", KEY_VALID, 0);

      // bounce on key 11: samples 1,0,1,1,1
      for (int v = 0; v < 5; v++) begin
         wait_sel(11, "wait_k11");
         pressed[11] = pat[v];
         if (v == 4) chk("k11_not_yet", KEY_HELD[11], 0);
         wait_sel(0, "wait_k0");
      end
      tick(3);
      chk("k11_held", KEY_HELD[11], 1);
      chk("k11_code", KEY_CODE, 11);
      KEY_READY = 1'b1;
      tick(1);
      KEY_READY = 1'b0;
      chk("k11_one_evt", KEY_VALID, 0);
      pressed[11] = 1'b0;
      tick(4 * VISIT);

      // overflow: keys 0,1,2,3,5 with no consumer
      wait_sel(6, "wait_ovf_start");
      pressed = 12'h02F;
      tick(4 * VISIT);
      chk("ovf_set", OVF, 1);
      chk("ovf_held", KEY_HELD, 12'h02F);
      for (int i = 0; i < 4; i++) begin
         chk("ovf_pop_code", KEY_CODE, i);
         chk("ovf_pop_valid", KEY_VALID, 1);
         KEY_READY = 1'b1;
         tick(1);
         KEY_READY = 1'b0;
      end
      chk("ovf_empty", KEY_VALID, 0);
      chk("ovf_code_hold", KEY_CODE, 3);
      chk("ovf_sticky", OVF, 1);
      CLR_OVF = 1'b1;
      tick(1);
      CLR_OVF = 1'b0;
      chk("ovf_clear", OVF, 0);
      pressed = 12'h000;
      tick(4 * VISIT);

      // full FIFO with a pop coinciding with the push of key 7
      wait_sel(6, "wait_full_start");
      pressed = 12'h00F;
      tick(4 * VISIT);
      chk("full_code0", KEY_CODE, 0);
      pressed[7] = 1'b1;
      t = 0;
      while (!(m_pend && m_pcode == 7) && t < 600) begin
         tick(1);
         t++;
      end
      if (t >= 600) chk("k7_push_timeout", t, 0);
      KEY_READY = 1'b1;
      tick(1);
      KEY_READY = 1'b0;
      chk("k7_no_ovf", OVF, 0);
      chk("k7_head", KEY_CODE, 1);

      // freeze mid-step while draining the queue
      wait_sel((m_idx + 1) % NUM_KEYS, "wait_step");
      tick(4);
      EN = 1'b0;
      frz_sel = m_idx;
      for (int i = 0; i < 4; i++) begin
         tick(2);
         chk("frz_pop_code", KEY_CODE, exp7[i]);
         KEY_READY = 1'b1;
         tick(1);
         KEY_READY = 1'b0;
      end
      tick(38);
      chk("frz_sel", SEL, frz_sel);
      chk("frz_held", KEY_HELD, 12'h08F);
      chk("frz_empty", KEY_VALID, 0);
      EN = 1'b1;
      pressed = 12'h000;
      tick(4 * VISIT);

      // random key activity, bounce noise, consumer stalls, enable gaps
      for (int c = 0; c < 5000; c++) begin
         noise = ($urandom_range(15) == 0);
         if ($urandom_range(99) == 0) begin
            k = $urandom_range(11);
            pressed[k] = ~pressed[k];
         end
         if ((c % 1000) < 500) KEY_READY = ($urandom_range(7) == 0);
         else KEY_READY = ($urandom_range(1) == 0);
         CLR_OVF = ($urandom_range(31) == 0);
         EN = ($urandom_range(15) != 0);
         tick(1);
      end
      noise = 1'b0;
      KEY_READY = 1'b0;
      CLR_OVF = 1'b0;
      EN = 1'b1;
      pressed = 12'h000;
      tick(4 * VISIT);

      // mid-scan reset with queued events and overflow pending
      wait_sel(6, "wait_rst_start");
      pressed = 12'h02F;
      tick(4 * VISIT);
      chk("pre_rst_ovf", OVF, 1);
      tick(3);
      RST = 1'b0;
      #1;
      chk("mid_rst_sel", SEL, 0);
      chk("mid_rst_valid", KEY_VALID, 0);
      chk("mid_rst_ovf", OVF, 0);
      chk("mid_rst_held", KEY_HELD, 0);
      pressed = 12'h000;
      tick(2);
      RST = 1'b1;
      tick(200);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
